face_level_selector: RTL and testbench
======================================

// Module: face_level_selector
// PURPOSE
//   Upstream feeder for the VGA face renderer's 2-bit face_select input.
//   Tracks the peak |amplitude| of the incoming audio sample stream over fixed
//   windows and classifies it into one of four faces (0 = calm .. 3 = screaming).
//   Applies hysteresis and a minimum hold time so the displayed face does not flicker.
// PARAMETERS
//   SAMPLE_W     16          signed audio sample width
//   WINDOW_LEN   1024        samples per peak window (>=2)
//   HOLD_CYCLES  12_500_000  min clk cycles a new face is held (250 ms @ 50 MHz, >=1)
//   THR1         2048        peak >= THR1 -> face 1
//   THR2         8192        peak >= THR2 -> face 2
//   THR3         20480       peak >= THR3 -> face 3 (THR1<THR2<THR3)
//   HYST         512         downward margin (HYST < THR1)
// PORTS
//   clk           in   1         system clock (50 MHz)
//   reset_n       in   1         asynchronous active-low reset
//   sample_valid  in   1         one-cycle strobe, sample_data valid
//   sample_data   in   SAMPLE_W  signed two's-complement audio sample
//   sw_override   in   3         [2]=override enable, [1:0]=forced face (FACE_OVERRIDE_EN only)
//   face_select   out  2         face index to VGA renderer
//   face_change   out  1         one-cycle pulse when face_select changes
//   level_peak    out  SAMPLE_W  peak |sample| of last completed window (unsigned)
// BEHAVIOUR
//   Reset: face_select=0, face_change=0, level_peak=0, peak acc=0, sample cnt=0,
//     hold cnt=0, FSM=IDLE. All outputs registered.
//   Abs: |x|; most-negative value saturates to 2^(SAMPLE_W-1)-1.
//   Window: on sample_valid, acc<=max(acc,|x|), cnt++. On the valid sample with
//     cnt==WINDOW_LEN-1: level_peak<=max(acc,|x|) (closing sample included),
//     acc<=0, cnt<=0, internal win_done pulses next cycle. No valid -> no change.
//   Classify (on win_done, current face k): up-move when peak >= THR of higher
//     face; down-move to face j<k only when peak < THR_(j+1)-HYST. Multi-step
//     jumps (0->3, 3->0) go direct; no intermediate faces.
//   FSM IDLE: win_done with target!=face -> face_select<=target, face_change=1
//     for one cycle, hold cnt<=HOLD_CYCLES-1, go HOLD. target==face -> stay.
//   FSM HOLD: hold cnt decrements each clk; win_done ignored for face update
//     (level_peak still updates); cnt==0 -> IDLE. First window closing after
//     return to IDLE is evaluated normally.
//   Latency: closing valid sample at cycle N -> level_peak at N+1, face_select
//     and face_change at N+2.
//   sample_valid every cycle is legal; no backpressure, no sample dropped.
//   Async reset mid-window or mid-hold discards all state; restart from face 0.
// CONFIGURATION
//   FACE_OVERRIDE_EN defined: sw_override port exists. While sw_override[2]=1,
//     face_select<=sw_override[1:0] one cycle later, hysteresis/hold bypassed,
//     face_change pulses on each value change; window tracking keeps running.
//     On release (1->0): face keeps forced value, FSM enters HOLD with full
//     HOLD_CYCLES, then resumes automatic control.
//   Undefined: port absent; selection purely automatic.
// TESTING
//   1 Reset, no samples for 10k cycles -> face_select=0, face_change never pulses.
//   2 1024 samples of +/-1000 then 1024 of 9000 -> level_peak=1000 then 9000;
//     face 0 -> 2 exactly 2 cycles after 2048th valid, single face_change pulse.
//   3 Face 2, HOLD_CYCLES=100, window peak 100 mid-hold -> no change until hold
//     expires; next window peak 100 -> face 0 (direct jump).
//   4 Face 1, peak 1600 (>=THR1-HYST) -> stays 1; peak 1500 -> face 0.
//   5 Single sample -32768 in window -> level_peak=32767, face 3;
//     sample_valid held high continuously -> window closes every 1024 cycles.
//   6 FACE_OVERRIDE_EN: sw_override=3'b110 -> face 2 next cycle; release ->
//     face stays 2 for HOLD_CYCLES, then follows audio; reset_n low mid-hold -> face 0.

Source files
------------

// File: rtl/face_level_selector_if.sv
// Audio-in / face-out bundle for face_level_selector.
// sw_override is present only when FACE_OVERRIDE_EN is defined.
interface face_level_selector_if #(
  parameter int SAMPLE_W = 16
);
  logic                       sample_valid;
  logic signed [SAMPLE_W-1:0] sample_data;
`ifdef FACE_OVERRIDE_EN
  logic [2:0]                 sw_override;
`endif
  logic [1:0]                 face_select;
  logic                       face_change;
  logic [SAMPLE_W-1:0]        level_peak;

`ifdef FACE_OVERRIDE_EN
  modport master (output sample_valid, output sample_data, output sw_override,
                  input face_select, input face_change, input level_peak);
  modport slave  (input sample_valid, input sample_data, input sw_override,
                  output face_select, output face_change, output level_peak);
`else
  modport master (output sample_valid, output sample_data,
                  input face_select, input face_change, input level_peak);
  modport slave  (input sample_valid, input sample_data,
                  output face_select, output face_change, output level_peak);
`endif
endinterface

// File: rtl/face_level_selector.sv
// Windowed peak-amplitude tracker that picks one of four faces with hysteresis and hold time.
// Optional manual face override is compiled in with FACE_OVERRIDE_EN.
module face_level_selector #(
  parameter int SAMPLE_W    = 16,
  parameter int WINDOW_LEN  = 1024,
  parameter int HOLD_CYCLES = 12_500_000,
  parameter int THR1        = 2048,
  parameter int THR2        = 8192,
  parameter int THR3        = 20480,
  parameter int HYST        = 512
) (
  input  logic                 clk,
  input  logic                 reset_n,
  face_level_selector_if.slave bus
);

  localparam int CNT_W  = (WINDOW_LEN > 1) ? $clog2(WINDOW_LEN) : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(WINDOW_LEN - 1);
  localparam logic [HOLD_W-1:0]   HOLD_INIT = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [SAMPLE_W-1:0] MAX_POS   = {1'b0, {(SAMPLE_W-1){1'b1}}};
  localparam logic [SAMPLE_W-1:0] MOST_NEG  = {1'b1, {(SAMPLE_W-1){1'b0}}};

  localparam logic [SAMPLE_W-1:0] UP1 = SAMPLE_W'(THR1);
  localparam logic [SAMPLE_W-1:0] UP2 = SAMPLE_W'(THR2);
  localparam logic [SAMPLE_W-1:0] UP3 = SAMPLE_W'(THR3);
  localparam logic [SAMPLE_W-1:0] DN1 = SAMPLE_W'(THR1 - HYST);
  localparam logic [SAMPLE_W-1:0] DN2 = SAMPLE_W'(THR2 - HYST);
  localparam logic [SAMPLE_W-1:0] DN3 = SAMPLE_W'(THR3 - HYST);

  typedef enum logic {IDLE, HOLD} state_e;

  logic [SAMPLE_W-1:0] acc_q, level_peak_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                win_done_q;
  logic [SAMPLE_W-1:0] abs_s, peak_s;
  logic [1:0]          up_s, target_s;

  state_e              state_q, state_d;
  logic [1:0]          face_q, face_d;
  logic                change_q, change_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
`ifdef FACE_OVERRIDE_EN
  logic                ovr_q;
`endif

  // The most negative sample has no positive twin, so it clamps to full scale.
  always_comb begin
    abs_s = $unsigned(bus.sample_data);
    if (bus.sample_data[SAMPLE_W-1]) begin
      if ($unsigned(bus.sample_data) == MOST_NEG) abs_s = MAX_POS;
      else                                       abs_s = $unsigned(-bus.sample_data);
    end
    peak_s = (abs_s > acc_q) ? abs_s : acc_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q        <= '0;
      cnt_q        <= '0;
      level_peak_q <= '0;
      win_done_q   <= 1'b0;
    end else begin
      win_done_q <= 1'b0;
      if (bus.sample_valid) begin
        if (cnt_q == CNT_LAST) begin
          level_peak_q <= peak_s;
          acc_q        <= '0;
          cnt_q        <= '0;
          win_done_q   <= 1'b1;
        end else begin
          acc_q <= peak_s;
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  // Upward moves use the plain thresholds; downward moves go to the lowest face whose
  // lowered threshold the peak has fallen under, so 3->0 happens in one step.
  always_comb begin
    if      (level_peak_q >= UP3) up_s = 2'd3;
    else if (level_peak_q >= UP2) up_s = 2'd2;
    else if (level_peak_q >= UP1) up_s = 2'd1;
    else                          up_s = 2'd0;

    target_s = face_q;
    if (up_s > face_q)                              target_s = up_s;
    else if (face_q != 2'd0 && level_peak_q < DN1)  target_s = 2'd0;
    else if (face_q >= 2'd2 && level_peak_q < DN2)  target_s = 2'd1;
    else if (face_q == 2'd3 && level_peak_q < DN3)  target_s = 2'd2;
  end

  always_comb begin
    state_d  = state_q;
    face_d   = face_q;
    hold_d   = hold_q;
    change_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_done_q && target_s != face_q) begin
          face_d   = target_s;
          change_d = 1'b1;
          hold_d   = HOLD_INIT;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (hold_q == '0) state_d = IDLE;
        else              hold_d  = hold_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
`ifdef FACE_OVERRIDE_EN
    // Releasing the switch keeps the forced face and starts a fresh hold period.
    if (bus.sw_override[2]) begin
      face_d   = bus.sw_override[1:0];
      change_d = (bus.sw_override[1:0] != face_q);
      hold_d   = '0;
      state_d  = IDLE;
    end else if (ovr_q) begin
      face_d   = face_q;
      change_d = 1'b0;
      hold_d   = HOLD_INIT;
      state_d  = HOLD;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      face_q   <= 2'd0;
      change_q <= 1'b0;
      hold_q   <= '0;
`ifdef FACE_OVERRIDE_EN
      ovr_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      face_q   <= face_d;
      change_q <= change_d;
      hold_q   <= hold_d;
`ifdef FACE_OVERRIDE_EN
      ovr_q    <= bus.sw_override[2];
`endif
    end
  end

  assign bus.face_select = face_q;
  assign bus.face_change = change_q;
  assign bus.level_peak  = level_peak_q;

endmodule

// File: tb/tb_face_level_selector.sv
// Directed bench for face_level_selector with a short window and hold so every case runs quickly.
// Override scenarios are exercised only when FACE_OVERRIDE_EN is defined.
module tb_face_level_selector;

  localparam int WIN  = 16;
  localparam int HOLD = 100;

  logic clk;
  logic reset_n;
  int   testCount   = 0;
  int   failCount   = 0;
  int   changeCount = 0;

  face_level_selector_if #(.SAMPLE_W(16)) bus ();

  face_level_selector #(
    .SAMPLE_W(16), .WINDOW_LEN(WIN), .HOLD_CYCLES(HOLD),
    .THR1(2048), .THR2(8192), .THR3(20480), .HYST(512)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus.face_change === 1'b1) changeCount++;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // mode 0: constant a, mode 1: alternating +a/-a, mode 2: one sample a, rest zero.
  task automatic applyStimulus(input int a, input int mode);
    for (int i = 0; i < WIN; i++) begin
      @(negedge clk);
      bus.sample_valid = 1'b1;
      case (mode)
        1:       bus.sample_data = (i % 2 == 1) ? 16'(-a) : 16'(a);
        2:       bus.sample_data = (i == 3) ? 16'(a) : 16'sd0;
        default: bus.sample_data = 16'(a);
      endcase
    end
    @(negedge clk);
    bus.sample_valid = 1'b0;
    bus.sample_data  = 16'sd0;
  endtask

  // Called one cycle after the closing sample: peak is visible now, face one cycle later.
  task automatic checkWindow(input string tag, input int expPeak, input int oldFace, input int newFace);
    checkOutput({tag, "_peak"}, int'(bus.level_peak), expPeak);
    checkOutput({tag, "_face_early"}, int'(bus.face_select), oldFace);
    @(negedge clk);
    checkOutput({tag, "_face"}, int'(bus.face_select), newFace);
    checkOutput({tag, "_change"}, int'(bus.face_change), (newFace != oldFace) ? 1 : 0);
    @(negedge clk);
    checkOutput({tag, "_change_end"}, int'(bus.face_change), 0);
  endtask

  initial begin
    reset_n          = 1'b0;
    bus.sample_valid = 1'b0;
    bus.sample_data  = 16'sd0;
`ifdef FACE_OVERRIDE_EN
    bus.sw_override  = 3'b000;
`endif
    idle(3);
    checkOutput("rst_face", int'(bus.face_select), 0);
    checkOutput("rst_change", int'(bus.face_change), 0);
    checkOutput("rst_peak", int'(bus.level_peak), 0);
    reset_n = 1'b1;

    idle(10000);
    checkOutput("quiet_face", int'(bus.face_select), 0);
    checkOutput("quiet_pulses", changeCount, 0);

    applyStimulus(1000, 1);
    checkWindow("w1000", 1000, 0, 0);
    applyStimulus(9000, 0);
    checkWindow("w9000", 9000, 0, 2);
    checkOutput("w9000_pulses", changeCount, 1);

    applyStimulus(100, 0);
    checkWindow("hold100", 100, 2, 2);
    idle(120);
    applyStimulus(100, 0);
    checkWindow("drop100", 100, 2, 0);
    checkOutput("drop_pulses", changeCount, 2);
    idle(120);

    applyStimulus(3000, 1);
    checkWindow("w3000", 3000, 0, 1);
    idle(120);
    applyStimulus(1600, 0);
    checkWindow("hyst1600", 1600, 1, 1);
    applyStimulus(1500, 1);
    checkWindow("hyst1500", 1500, 1, 0);
    checkOutput("hyst_pulses", changeCount, 4);
    idle(120);

    applyStimulus(-32768, 2);
    checkWindow("mostneg", 32767, 0, 3);
    for (int i = 0; i <= 2 * WIN; i++) begin
      @(negedge clk);
      if (i == WIN - 1) checkOutput("cont_open", int'(bus.level_peak), 32767);
      if (i == WIN)     checkOutput("cont_close1", int'(bus.level_peak), 5000);
      if (i < 2 * WIN) begin
        bus.sample_valid = 1'b1;
        bus.sample_data  = (i < WIN) ? 16'sd5000 : -16'sd7000;
      end else begin
        bus.sample_valid = 1'b0;
        bus.sample_data  = 16'sd0;
      end
    end
    checkOutput("cont_close2", int'(bus.level_peak), 7000);
    checkOutput("cont_face", int'(bus.face_select), 3);
    idle(120);

    applyStimulus(9000, 0);
    checkWindow("down3to2", 9000, 3, 2);
    idle(10);
    reset_n = 1'b0;
    @(negedge clk);
    checkOutput("midhold_rst_face", int'(bus.face_select), 0);
    checkOutput("midhold_rst_peak", int'(bus.level_peak), 0);
    reset_n = 1'b1;
    applyStimulus(3000, 0);
    checkWindow("after_rst", 3000, 0, 1);
    idle(120);

`ifdef FACE_OVERRIDE_EN
    bus.sw_override = 3'b110;
    @(negedge clk);
    checkOutput("ovr_face2", int'(bus.face_select), 2);
    checkOutput("ovr_change2", int'(bus.face_change), 1);
    @(negedge clk);
    checkOutput("ovr_change2_end", int'(bus.face_change), 0);
    bus.sw_override = 3'b111;
    @(negedge clk);
    checkOutput("ovr_face3", int'(bus.face_select), 3);
    checkOutput("ovr_change3", int'(bus.face_change), 1);
    bus.sw_override = 3'b000;
    idle(2);
    checkOutput("ovr_release_face", int'(bus.face_select), 3);
    applyStimulus(100, 0);
    checkWindow("ovr_hold", 100, 3, 3);
    idle(120);
    applyStimulus(100, 0);
    checkWindow("ovr_resume", 100, 3, 0);
    bus.sw_override = 3'b101;
    @(negedge clk);
    bus.sw_override = 3'b000;
    idle(5);
    reset_n = 1'b0;
    @(negedge clk);
    checkOutput("ovr_rst_face", int'(bus.face_select), 0);
    reset_n = 1'b1;
    idle(2);
`endif

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
